// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle 16-bit-instruction core with an 8-entry
// register file and Z/N flags. Each instruction takes four cycles
// (FETCH, DECODE, EXEC, WB). An executed HALT parks the core in HALT until rst.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   imem_en         ROM read enable (high in FETCH, low while rst is high)
//   imem_addr       ROM address (tracks pc)
//   imem_data       ROM data, valid the cycle after imem_en is sampled high
//   pc              current program counter
//   halted          high once an executed HALT has retired
//   flag_z, flag_n  zero / negative flags
//   dbg_sel         debug register select
//   dbg_data        combinational read of reg[dbg_sel]
//   retired         (RETIRE_COUNTER_EN only) count of completed WB cycles
//
// Optional feature macro: RETIRE_COUNTER_EN.
module multicycle_core #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              flag_z,
    output logic              flag_n,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
`ifdef RETIRE_COUNTER_EN
    ,
    output logic [31:0]       retired
`endif
);
    localparam int unsigned REG_N = 8;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       ir;
    logic [DATA_W-1:0] regs [REG_N];
    logic [DATA_W-1:0] result;
    logic              cond_ok;

    // Instruction fields decoded from the instruction register
    logic [1:0]      f_cond;
    logic [3:0]      f_op;
    logic [2:0]      f_rd;
    logic [2:0]      f_rs1;
    logic [2:0]      f_rs2;
    logic [3:0]      f_sh;
    logic [6:0]      f_imm7;
    logic [PC_W-1:0] f_target;

    assign f_cond   = ir[15:14];
    assign f_op     = ir[13:10];
    assign f_rd     = ir[9:7];
    assign f_rs1    = ir[6:4];
    assign f_rs2    = ir[3:1];
    assign f_sh     = ir[3:0];
    assign f_imm7   = ir[6:0];
    assign f_target = ir[PC_W-1:0];

    assign imem_addr = pc;
    assign dbg_data  = regs[dbg_sel];

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_c;
    logic              cond_c;
    logic              writes_c;

    // ALU result and condition evaluation, latched in EXEC
    always_comb begin
        op_a     = regs[f_rs1];
        op_b     = regs[f_rs2];
        alu_c    = '0;
        cond_c   = 1'b1;
        writes_c = (f_op >= OP_ADD) && (f_op <= OP_LDI);
        case (f_op)
            OP_ADD:  alu_c = op_a + op_b;
            OP_SUB:  alu_c = op_a - op_b;
            OP_AND:  alu_c = op_a & op_b;
            OP_OR:   alu_c = op_a | op_b;
            OP_XOR:  alu_c = op_a ^ op_b;
            OP_NOT:  alu_c = ~op_a;
            OP_SHL:  alu_c = op_a << f_sh;
            OP_SHR:  alu_c = op_a >> f_sh;
            OP_MOV:  alu_c = op_a;
            OP_LDI:  alu_c = DATA_W'(f_imm7);
            default: alu_c = '0;
        endcase
        case (f_cond)
            2'b00:   cond_c = 1'b1;
            2'b01:   cond_c = flag_z;
            2'b10:   cond_c = ~flag_z;
            default: cond_c = flag_n;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ROM enable
    always_comb begin
        state_nxt = state;
        imem_en   = 1'b0;
        case (state)
            S_FETCH: begin
                imem_en   = ~rst;
                state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB:     state_nxt = (cond_ok && (f_op == OP_HALT)) ? S_HALT : S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Datapath: instruction capture, execute latch, writeback and pc update
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= '0;
            ir      <= '0;
            result  <= '0;
            cond_ok <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            halted  <= 1'b0;
            for (int unsigned i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                S_DECODE: ir <= imem_data;
                S_EXEC: begin
                    result  <= alu_c;
                    cond_ok <= cond_c;
                end
                S_WB: begin
                    if (cond_ok) begin
                        if (writes_c) begin
                            regs[f_rd] <= result;
                            flag_z     <= (result == '0);
                            flag_n     <= result[DATA_W-1];
                        end
                        if (f_op == OP_JMP) begin
                            pc <= f_target;
                        end else if (f_op == OP_HALT) begin
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RETIRE_COUNTER_EN
    // One count per WB; HALT state never reaches WB again, so the count freezes
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (state == S_WB) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_core.sv
`timescale 1ns/100ps
module tb_multicycle_core;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 4;
    localparam int unsigned SW = 8 * DW + PW + 3;

    logic          clk;
    logic          rst;
    logic          imem_en;
    logic [PW-1:0] imem_addr;
    logic [15:0]   imem_data;
    logic [PW-1:0] pc;
    logic          halted;
    logic          flag_z;
    logic          flag_n;
    logic [2:0]    dbg_sel;
    logic [DW-1:0] dbg_data;
`ifdef RETIRE_COUNTER_EN
    logic [31:0]   retired;
`endif

    int total;
    int bad;

    multicycle_core #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk(clk),
        .rst(rst),
        .imem_en(imem_en),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .pc(pc),
        .halted(halted),
        .flag_z(flag_z),
        .flag_n(flag_n),
        .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
`ifdef RETIRE_COUNTER_EN
        ,
        .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM
    logic [15:0] rom [16];
    always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

    // Instruction-level reference model
    logic [DW-1:0] m_regs [8];
    logic          m_z, m_n, m_halt;
    logic [PW-1:0] m_pc;
    int unsigned   m_ret;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_z = 0; m_n = 0; m_halt = 0; m_pc = '0; m_ret = 0;
    endtask

    task automatic model_step();
        logic [15:0]   w;
        logic [DW-1:0] a, b, r;
        logic [3:0]    op;
        logic          go;
        if (m_halt) return;
        w  = rom[m_pc];
        op = w[13:10];
        a  = m_regs[w[6:4]];
        b  = m_regs[w[3:1]];
        case (w[15:14])
            2'd0: go = 1;
            2'd1: go = m_z;
            2'd2: go = !m_z;
            default: go = m_n;
        endcase
        m_ret++;
        if (!go) begin
            m_pc = m_pc + 1'b1;
            return;
        end
        case (op)
            4'h1: r = a + b;
            4'h2: r = a - b;
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h5: r = a ^ b;
            4'h6: r = ~a;
            4'h7: r = a << w[3:0];
            4'h8: r = a >> w[3:0];
            4'h9: r = a;
            4'hA: r = DW'(w[6:0]);
            default: r = '0;
        endcase
        if (op >= 4'h1 && op <= 4'hA) begin
            m_regs[w[9:7]] = r;
            m_z = (r == 0);
            m_n = r[DW-1];
        end
        if (op == 4'hB) m_pc = w[PW-1:0];
        else if (op == 4'hF) m_halt = 1;
        else m_pc = m_pc + 1'b1;
    endtask

    function automatic logic [SW-1:0] model_snap();
        logic [SW-1:0] s;
        for (int i = 0; i < 8; i++) s[i*DW +: DW] = m_regs[i];
        s[SW-1 -: PW+3] = {m_pc, m_z, m_n, m_halt};
        return s;
    endfunction

    // Architectural state seen through the DUT ports
    task automatic dut_snap(output logic [SW-1:0] s);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #0.1;
            s[i*DW +: DW] = dbg_data;
        end
        s[SW-1 -: PW+3] = {pc, flag_z, flag_n, halted};
    endtask

    task automatic read_reg(input int idx, output logic [DW-1:0] v);
        dbg_sel = 3'(idx);
        #0.1;
        v = dbg_data;
    endtask

    function automatic logic [15:0] enc(input logic [1:0] c, input logic [3:0] op,
                                        input logic [2:0] rd, input logic [6:0] lo);
        return {c, op, rd, lo};
    endfunction
    function automatic logic [15:0] alu(input logic [1:0] c, input logic [3:0] op,
                                        input logic [2:0] rd, input logic [2:0] s1, input logic [2:0] s2);
        return enc(c, op, rd, {s1, s2, 1'b0});
    endfunction
    function automatic logic [15:0] shf(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] s1, input logic [3:0] sh);
        return enc(2'd0, op, rd, {s1, sh});
    endfunction
    function automatic logic [15:0] ldi(input logic [1:0] c, input logic [2:0] rd, input logic [6:0] imm);
        return enc(c, 4'hA, rd, imm);
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reset, then release at a negedge: the current cycle is cycle 0 (FETCH)
    task automatic start();
        @(negedge clk);
        rst = 1;
        cycles(2);
        rst = 0;
        model_reset();
    endtask

    task automatic step_instr();
        cycles(4);
        model_step();
    endtask

    task automatic test_reset();
        logic [SW-1:0] ds;
        clear_rom();
        rst = 1;
        cycles(3);
        total++;
        if (imem_en !== 1'b0) begin
            bad++; $display("FAIL reset_imem_en got=%0b exp=0", imem_en);
        end
        dut_snap(ds);
        model_reset();
        total++;
        if (ds !== model_snap()) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", ds, model_snap());
        end
        rst = 0;
        total++;
        #0.1;
        if (imem_en !== 1'b1 || imem_addr !== '0) begin
            bad++; $display("FAIL first_fetch got=%0b/%0h exp=1/0", imem_en, imem_addr);
        end
    endtask

    task automatic test_add_halt();
        logic [DW-1:0] v;
        clear_rom();
        rom[0] = ldi(2'd0, 3'd1, 7'd5);
        rom[1] = ldi(2'd0, 3'd2, 7'd3);
        rom[2] = alu(2'd0, 4'h1, 3'd3, 3'd1, 3'd2);
        rom[3] = enc(2'd0, 4'hF, 3'd0, 7'd0);
        start();
        model_step(); model_step();
        cycles(11);
        read_reg(3, v);
        total++;
        if (v !== m_regs[3]) begin
            bad++; $display("FAIL add_r3_cycle11 got=%h exp=%h", v, m_regs[3]);
        end
        model_step();
        cycles(1);
        read_reg(3, v);
        total++;
        if (v !== m_regs[3] || v !== 16'd8) begin
            bad++; $display("FAIL add_r3_cycle12 got=%h exp=%h", v, m_regs[3]);
        end
        cycles(3);
        total++;
        if (halted !== 1'b0) begin
            bad++; $display("FAIL halted_cycle15 got=%0b exp=0", halted);
        end
        model_step();
        cycles(1);
        total++;
        if ({halted, pc, flag_z} !== {m_halt, m_pc, m_z} || pc !== 4'd3) begin
            bad++; $display("FAIL halt_cycle16 got=%0b/%0h/%0b exp=%0b/%0h/%0b",
                            halted, pc, flag_z, m_halt, m_pc, m_z);
        end
        cycles(9);
        total++;
        if ({imem_en, halted, pc} !== {1'b0, 1'b1, m_pc}) begin
            bad++; $display("FAIL halt_hold got=%0b/%0b/%0h exp=0/1/%0h", imem_en, halted, pc, m_pc);
        end
    endtask

    task automatic test_cond_flags();
        logic [SW-1:0] ds;
        logic [DW-1:0] v5, v6;
        clear_rom();
        rom[0] = alu(2'd0, 4'h2, 3'd4, 3'd2, 3'd2);
        rom[1] = ldi(2'd2, 3'd6, 7'd9);
        rom[2] = ldi(2'd1, 3'd5, 7'd7);
        rom[3] = enc(2'd0, 4'hF, 3'd0, 7'd0);
        start();
        for (int k = 0; k < 4; k++) begin
            step_instr();
            dut_snap(ds);
            total++;
            if (ds !== model_snap()) begin
                bad++; $display("FAIL cond_step%0d got=%h exp=%h", k, ds, model_snap());
            end
        end
        read_reg(5, v5);
        read_reg(6, v6);
        total++;
        if ({v5, v6, flag_z, flag_n} !== {16'd7, 16'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL cond_final got=%h/%h/%0b/%0b exp=7/0/0/0", v5, v6, flag_z, flag_n);
        end
    endtask

    task automatic test_shift();
        logic [SW-1:0] ds;
        clear_rom();
        rom[0] = ldi(2'd0, 3'd1, 7'd1);
        rom[1] = shf(4'h7, 3'd2, 3'd1, 4'd15);
        rom[2] = shf(4'h8, 3'd3, 3'd2, 4'd15);
        rom[3] = enc(2'd0, 4'hF, 3'd0, 7'd0);
        start();
        for (int k = 0; k < 4; k++) begin
            step_instr();
            dut_snap(ds);
            total++;
            if (ds !== model_snap()) begin
                bad++; $display("FAIL shift_step%0d got=%h exp=%h", k, ds, model_snap());
            end
            if (k == 1) begin
                total++;
                if ({ds[2*DW +: DW], flag_n} !== {16'h8000, 1'b1}) begin
                    bad++; $display("FAIL shl_msb got=%h/%0b exp=8000/1", ds[2*DW +: DW], flag_n);
                end
            end
        end
    endtask

    task automatic test_pc_wrap_jmp();
        clear_rom();
        start();
        for (int k = 0; k < 18; k++) begin
            step_instr();
            total++;
            if (pc !== m_pc) begin
                bad++; $display("FAIL wrap_pc%0d got=%0d exp=%0d", k, pc, m_pc);
            end
`ifdef RETIRE_COUNTER_EN
            total++;
            if (retired !== m_ret) begin
                bad++; $display("FAIL retired%0d got=%0d exp=%0d", k, retired, m_ret);
            end
`endif
        end
        rom[5] = enc(2'd0, 4'hB, 3'd0, 7'd2);
        start();
        for (int k = 0; k < 12; k++) begin
            step_instr();
            total++;
            if (pc !== m_pc) begin
                bad++; $display("FAIL jmp_pc%0d got=%0d exp=%0d", k, pc, m_pc);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [SW-1:0] ds;
        logic [DW-1:0] v;
        clear_rom();
        rom[0] = ldi(2'd0, 3'd1, 7'd5);
        rom[1] = ldi(2'd0, 3'd2, 7'd3);
        rom[2] = alu(2'd0, 4'h1, 3'd3, 3'd1, 3'd2);
        rom[3] = enc(2'd0, 4'hF, 3'd0, 7'd0);
        start();
        cycles(10);
        rst = 1;
        cycles(1);
        model_reset();
        dut_snap(ds);
        total++;
        if (ds !== model_snap() || imem_en !== 1'b0) begin
            bad++; $display("FAIL midreset_state got=%h/%0b exp=%h/0", ds, imem_en, model_snap());
        end
        rst = 0;
        cycles(12);
        read_reg(3, v);
        total++;
        if (v !== 16'd8) begin
            bad++; $display("FAIL midreset_rerun got=%h exp=0008", v);
        end
    endtask

    task automatic test_illegal_skip();
        logic [SW-1:0] ds;
        clear_rom();
        rom[0] = ldi(2'd0, 3'd1, 7'd0);
        rom[1] = alu(2'd0, 4'hC, 3'd1, 3'd1, 3'd1);
        rom[2] = enc(2'd3, 4'hF, 3'd0, 7'd0);
        rom[3] = ldi(2'd0, 3'd2, 7'd4);
        rom[4] = enc(2'd0, 4'hF, 3'd0, 7'd0);
        start();
        for (int k = 0; k < 5; k++) begin
            step_instr();
            dut_snap(ds);
            total++;
            if (ds !== model_snap()) begin
                bad++; $display("FAIL illegal_step%0d got=%h exp=%h", k, ds, model_snap());
            end
            if (k == 2) begin
                total++;
                if ({halted, pc} !== {1'b0, 4'd3}) begin
                    bad++; $display("FAIL skipped_halt got=%0b/%0d exp=0/3", halted, pc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] ds;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
            start();
            for (int k = 0; k < 24; k++) begin
                step_instr();
                dut_snap(ds);
                total++;
                if (ds !== model_snap()) begin
                    bad++; $display("FAIL rand_p%0d_i%0d got=%h exp=%h", p, k, ds, model_snap());
                end
`ifdef RETIRE_COUNTER_EN
                total++;
                if (retired !== m_ret) begin
                    bad++; $display("FAIL rand_retired p%0d i%0d got=%0d exp=%0d", p, k, retired, m_ret);
                end
`endif
            end
        end
    endtask

    initial begin
        clk = 0;
        rst = 1;
        dbg_sel = '0;
        total = 0;
        bad = 0;
        test_reset();
        test_add_halt();
        test_cond_flags();
        test_shift();
        test_pc_wrap_jmp();
        test_reset_mid();
        test_illegal_skip();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
